pl9823_chain_tx: RTL and testbench



---
 rtl/pl9823_chain_tx.sv | 175 +++++++++++++++++
 tb/tb_pl9823_chain_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pl9823_chain_tx.sv
// pl9823_chain_tx -- serial driver for a daisy-chain of PL9823 RGB LEDs.
// Holds one 24-bit {R,G,B} word per LED and, on request, shifts the whole
// chain out MSB first with pulse-width bit encoding, followed by a low latch gap.
// Optional build macro: PL9823_AUTO_REFRESH_EN (continuous refresh, START ignored).
module pl9823_chain_tx #(
  parameter int N_LEDS  = 3,
  parameter int T_BIT   = 86,
  parameter int T0H     = 18,
  parameter int T1H     = 68,
  parameter int T_RESET = 3000,
  parameter int AW      = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [23:0]   WR_RGB,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic          OUT
);

  localparam int BW = $clog2(T_BIT);
  localparam int LW = $clog2(T_RESET + 1);

  localparam logic [BW-1:0] T0H_W      = BW'(T0H);
  localparam logic [BW-1:0] T1H_W      = BW'(T1H);
  localparam logic [BW-1:0] T_BIT_LAST = BW'(T_BIT - 1);
  localparam logic [LW-1:0] T_RESET_W  = LW'(T_RESET);
  localparam logic [AW-1:0] LED_LAST   = AW'(N_LEDS - 1);
  localparam logic [AW:0]   N_LEDS_CMP = (AW + 1)'(N_LEDS);

  // Timing relations the encoding depends on; reject bad builds early.
  if ((T0H >= T1H) || (T1H >= T_BIT) || (N_LEDS < 1)) begin : g_bad_params
    $error("pl9823_chain_tx: require T0H < T1H < T_BIT and N_LEDS >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BIT   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t          state_q;
  logic [23:0]     mem_q [N_LEDS];
  logic [23:0]     shreg_q;
  logic [BW-1:0]   bit_tmr_q;
  logic [4:0]      bit_idx_q;
  logic [AW-1:0]   led_idx_q;
  logic [LW-1:0]   latch_tmr_q;
  logic            out_q;
  logic            busy_q;
  logic            done_q;

  logic [BW-1:0]   hi_len_d;
  logic [AW-1:0]   led_idx_d;

  // High time of the bit currently on the line and index of the next LED word.
  always_comb begin
    hi_len_d  = T0H_W;
    led_idx_d = led_idx_q + {{(AW-1){1'b0}}, 1'b1};
    if (shreg_q[23]) begin
      hi_len_d = T1H_W;
    end else begin
      hi_len_d = T0H_W;
    end
  end

  // Colour buffer: host writes land here in any state; contents survive reset.
  always_ff @(posedge CLK) begin
    if (WR_EN && ({1'b0, WR_ADDR} < N_LEDS_CMP)) begin
      mem_q[WR_ADDR] <= WR_RGB;
    end
  end

  // Frame sequencer: fetch words, time each bit, then hold the latch gap.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_LATCH;
      shreg_q     <= 24'h000000;
      bit_tmr_q   <= '0;
      bit_idx_q   <= 5'd0;
      led_idx_q   <= '0;
      latch_tmr_q <= '0;
      out_q       <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          out_q  <= 1'b0;
          busy_q <= 1'b0;
`ifdef PL9823_AUTO_REFRESH_EN
          // Unreachable in refresh mode; recover straight into a frame.
          state_q <= ST_LOAD;
          busy_q  <= 1'b1;
`else
          if (START) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
`endif
        end
        ST_LOAD: begin
          // Read-before-write: a same-cycle write to LED 0 is seen next frame.
          shreg_q   <= mem_q[0];
          led_idx_q <= '0;
          bit_idx_q <= 5'd23;
          bit_tmr_q <= '0;
          out_q     <= 1'b0;
          state_q   <= ST_BIT;
        end
        ST_BIT: begin
          out_q <= (bit_tmr_q < hi_len_d);
          if (bit_tmr_q == T_BIT_LAST) begin
            bit_tmr_q <= '0;
            if (bit_idx_q == 5'd0) begin
              if (led_idx_q == LED_LAST) begin
                latch_tmr_q <= '0;
                state_q     <= ST_LATCH;
              end else begin
                // Next word fetched on the last cycle of this LED: no gap.
                led_idx_q <= led_idx_d;
                shreg_q   <= mem_q[led_idx_d];
                bit_idx_q <= 5'd23;
              end
            end else begin
              shreg_q   <= {shreg_q[22:0], 1'b0};
              bit_idx_q <= bit_idx_q - 5'd1;
            end
          end else begin
            bit_tmr_q <= bit_tmr_q + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        ST_LATCH: begin
          out_q <= 1'b0;
          if (latch_tmr_q == T_RESET_W) begin
            done_q      <= 1'b1;
            latch_tmr_q <= '0;
`ifdef PL9823_AUTO_REFRESH_EN
            // The DONE cycle doubles as the load cycle of the next frame.
            shreg_q   <= mem_q[0];
            led_idx_q <= '0;
            bit_idx_q <= 5'd23;
            bit_tmr_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_BIT;
`else
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
`endif
          end else begin
            latch_tmr_q <= latch_tmr_q + {{(LW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          out_q       <= 1'b0;
          busy_q      <= 1'b1;
          latch_tmr_q <= '0;
          state_q     <= ST_LATCH;
        end
      endcase
    end
  end

  assign OUT  = out_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_pl9823_chain_tx.sv
// Self-checking bench for pl9823_chain_tx: decodes the serial line into pulses
// and compares rise times, high widths, DONE/BUSY timing against a frame model
// built from the colour buffer contents and the word-fetch schedule.
`timescale 1ns/1ps
module tb_pl9823_chain_tx;

  localparam int N_LEDS  = 3;
  localparam int T_BIT   = 86;
  localparam int T0H     = 18;
  localparam int T1H     = 68;
  localparam int T_RESET = 3000;
  localparam int AW      = 2;
  localparam int LED_CYC = 24 * T_BIT;
  localparam int FRAME   = N_LEDS * LED_CYC;
  localparam int D_OFF   = 2 + FRAME + T_RESET;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_rgb;
  logic          start;
  logic          busy;
  logic          done;
  logic          out_s;

  always #10 clk = ~clk;

  pl9823_chain_tx #(
    .N_LEDS(N_LEDS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_RGB(wr_rgb),
    .START(start), .BUSY(busy), .DONE(done), .OUT(out_s)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int t; int addr; logic [23:0] val; } wr_t;
  wr_t         wr_q[$];
  logic [23:0] model_buf [N_LEDS];
  int          rise_q[$];
  int          width_q[$];
  int          done_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_led(input int a, input logic [23:0] v);
    wr_en = 1'b1; wr_addr = AW'(a); wr_rgb = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < N_LEDS) model_buf[a] = v;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

`ifdef PL9823_AUTO_REFRESH_EN
  initial begin
    int n_busy_low = 0;
    int prev = 0;
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_rgb = 24'h0;
    @(posedge clk); #1;
    write_led(0, 24'hFF0000);
    write_led(1, 24'h000000);
    write_led(2, 24'h00FF01);
    rst_n = 1'b1;
    for (int i = 0; i < T_RESET + 1 + 2 * (FRAME + T_RESET + 1); i++) begin
      @(posedge clk); #1;
      if (out_s === 1'b1 && prev == 0) rise_q.push_back(i);
      if (out_s !== 1'b1 && prev == 1) width_q.push_back(i - rise_q[$]);
      prev = (out_s === 1'b1) ? 1 : 0;
      if (done === 1'b1) done_q.push_back(i);
      if (busy !== 1'b1) n_busy_low++;
    end
    check_val("auto/busy_low", n_busy_low, 0);
    check_val("auto/n_done", done_q.size(), 3);
    for (int k = 0; k < 3; k++)
      check_val($sformatf("auto/done%0d", k), (k < done_q.size()) ? done_q[k] : -1,
                T_RESET + k * (FRAME + T_RESET + 1));
    check_val("auto/n_rise", rise_q.size(), 2 * N_LEDS * 24);
    for (int i = 0; i < 2 * N_LEDS * 24; i++) begin
      int b = i % (N_LEDS * 24);
      logic [23:0] w = model_buf[b / 24];
      check_val($sformatf("auto/rise%0d", i), (i < rise_q.size()) ? rise_q[i] : -1,
                T_RESET + 1 + (i / (N_LEDS * 24)) * (FRAME + T_RESET + 1) + b * T_BIT);
      check_val($sformatf("auto/width%0d", i), (i < width_q.size()) ? width_q[i] : -1,
                w[23 - (b % 24)] ? T1H : T0H);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
`else
  // Hold reset for cyc edges, release, and check the reset-entry latch gap.
  task automatic do_reset(input string tag, input int cyc);
    int bad = 0, t_done = -1, n_done = 0, n_high = 0, bf = -1;
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (out_s !== 1'b0 || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    check_val({tag, "/in_reset"}, bad, 0);
    rst_n = 1'b1;
    for (int i = 0; i < T_RESET + 3; i++) begin
      @(posedge clk); #1;
      if (out_s !== 1'b0) n_high++;
      if (done === 1'b1) begin n_done++; if (t_done < 0) t_done = i; end
      if (busy !== 1'b1 && bf < 0) bf = i;
    end
    check_val({tag, "/out_low"}, n_high, 0);
    check_val({tag, "/n_done"}, n_done, 1);
    check_val({tag, "/done_t"}, t_done, T_RESET);
    check_val({tag, "/busy_fall"}, bf, T_RESET);
  endtask

  task automatic idle_check(input string tag, input int cyc);
    int bad = 0;
    start = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || out_s !== 1'b0 || done !== 1'b0) bad++;
    end
    check_val({tag, "/idle"}, bad, 0);
  endtask

  // mode 0: plain frame; 1: START held/pulsed while busy; 2: abort at bit 30.
  task automatic send_frame(input string tag, input int mode);
    logic [23:0] exp_w [N_LEDS];
    int t_end, prev, wi, n_exp, bf;
    for (int k = 0; k < N_LEDS; k++) exp_w[k] = model_buf[k];
    // LED k's word is taken at offset 1 + k*24*T_BIT; earlier writes make it.
    foreach (wr_q[i])
      if (wr_q[i].addr < N_LEDS && wr_q[i].t < 1 + wr_q[i].addr * LED_CYC)
        exp_w[wr_q[i].addr] = wr_q[i].val;
    rise_q.delete(); width_q.delete(); done_q.delete();
    bf = -1; prev = 0; wi = 0;
    t_end = (mode == 2) ? 2 + 30 * T_BIT : D_OFF + 3;
    for (int t = 0; t < t_end; t++) begin
      start = (t == 0) || (mode == 1 && (t < 3000 || t == 5000));
      wr_en = 1'b0;
      if (wi < wr_q.size() && wr_q[wi].t == t) begin
        wr_en = 1'b1; wr_addr = AW'(wr_q[wi].addr); wr_rgb = wr_q[wi].val; wi++;
      end
      @(posedge clk); #1;
      if (t == 0) check_val({tag, "/busy_rise"}, busy, 1);
      if (out_s === 1'b1 && prev == 0) rise_q.push_back(t);
      if (out_s !== 1'b1 && prev == 1) width_q.push_back(t - rise_q[$]);
      prev = (out_s === 1'b1) ? 1 : 0;
      if (done === 1'b1) done_q.push_back(t);
      if (busy !== 1'b1 && bf < 0) bf = t;
    end
    start = 1'b0; wr_en = 1'b0;
    foreach (wr_q[i]) if (wr_q[i].addr < N_LEDS) model_buf[wr_q[i].addr] = wr_q[i].val;
    wr_q.delete();
    n_exp = (mode == 2) ? 30 : N_LEDS * 24;
    check_val({tag, "/n_pulses"}, rise_q.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      logic [23:0] w = exp_w[i / 24];
      check_val($sformatf("%s/rise%0d", tag, i), (i < rise_q.size()) ? rise_q[i] : -1,
                2 + i * T_BIT);
      check_val($sformatf("%s/width%0d", tag, i), (i < width_q.size()) ? width_q[i] : -1,
                w[23 - (i % 24)] ? T1H : T0H);
    end
    if (mode != 2) begin
      check_val({tag, "/n_done"}, done_q.size(), 1);
      check_val({tag, "/done_t"}, (done_q.size() > 0) ? done_q[0] : -1, D_OFF);
      check_val({tag, "/busy_fall"}, bf, D_OFF);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_rgb = 24'h0;
    do_reset("por", 5);
    idle_check("por", 4);

    write_led(0, 24'hFF0000);
    write_led(1, 24'h000000);
    write_led(2, 24'h00FF01);
    send_frame("enc", 0);
    idle_check("enc", 4);

    send_frame("start_hold", 1);
    idle_check("start_hold", 4);

    // LED2 rewritten while LED0 is on the line; LED1 written one cycle
    // before its fetch and again in the fetch cycle itself.
    wr_q.push_back('{100, 2, 24'h0000FF});
    wr_q.push_back('{LED_CYC, 1, 24'hA5A5A5});
    wr_q.push_back('{LED_CYC + 1, 1, 24'h5A5A5A});
    wr_q.push_back('{LED_CYC + 2, 3, 24'hFFFFFF});
    send_frame("wr_early", 0);
    idle_check("wr_early", 2);

    wr_q.push_back('{2 * LED_CYC + 100, 0, 24'h123456});
    send_frame("wr_late", 0);
    idle_check("wr_late", 2);

    send_frame("abort", 2);
    do_reset("mid_rst", 3);
    idle_check("mid_rst", 2);
    send_frame("after_rst", 0);
    idle_check("after_rst", 2);

    for (int k = 0; k < N_LEDS; k++) write_led(k, 24'($urandom));
    write_led(3, 24'($urandom));
    wr_q.push_back('{int'($urandom_range(0, FRAME - 1)), int'($urandom_range(0, 3)),
                     24'($urandom)});
    send_frame("rand", 0);
    idle_check("rand", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
`endif

endmodule
